// File: rtl/interrupt_sequencer_pkg.sv
// Shared INTCON bit map, default vector and sequencer state type.
// Imported by the interrupt sequencer and its edge detector.
package interrupt_sequencer_pkg;

  localparam int GIE_BIT  = 7;
  localparam int PEIE_BIT = 6;
  localparam int T0IE_BIT = 5;
  localparam int INTE_BIT = 4;
  localparam int RBIE_BIT = 3;
  localparam int T0IF_BIT = 2;
  localparam int INTF_BIT = 1;
  localparam int RBIF_BIT = 0;

  localparam logic [12:0] INT_VECTOR_DEF = 13'h004;

  typedef enum logic {
    RUN   = 1'b0,
    ENTRY = 1'b1
  } seq_state_e;

  function automatic logic pending(input logic [7:0] ic);
    return (ic[T0IE_BIT] & ic[T0IF_BIT]) |
           (ic[INTE_BIT] & ic[INTF_BIT]) |
           (ic[RBIE_BIT] & ic[RBIF_BIT]);
  endfunction

endpackage

// File: rtl/int_edge_detect.sv
// INT pin synchroniser and selectable edge detector.
// Emits a 1-clock pulse on the edge chosen by intedg.
module int_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic int_pin,
  input  logic intedg,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   cur;

  assign cur = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], int_pin};
      prev <= cur;
    end
  end

  // Both terms use registered samples, so flipping intedg alone never fires.
  assign edge_pulse = intedg ? (cur & ~prev) : (~cur & prev);

endmodule

// File: rtl/interrupt_sequencer.sv
// INTCON owner and interrupt-entry sequencer for the 4-Q core.
// Forces flush-and-call at instruction boundaries; RETFIE re-arms GIE.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH    = 13,
  parameter logic [PC_WIDTH-1:0] INT_VECTOR  = INT_VECTOR_DEF,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          q_count,
  input  logic                instr_boundary,
  input  logic                intcon_wr_en,
  input  logic [7:0]          intcon_wr_data,
  output logic [7:0]          intcon_q,
  input  logic                int_pin,
  input  logic                intedg,
  input  logic                t0_ovf,
  input  logic                rb_change,
  input  logic                retfie_en,
  output logic                irq_take,
  output logic                irq_flush,
  output logic [PC_WIDTH-1:0] irq_vector,
  output logic                wake
);

  seq_state_e state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [7:0] intcon, intcon_n;
  logic       int_edge;
  logic       pend;
  logic       take;

  int_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk       (clk),
    .rst       (rst),
    .int_pin   (int_pin),
    .intedg    (intedg),
    .edge_pulse(int_edge)
  );

  assign pend = pending(intcon);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= 2'd0;
      intcon <= 8'h00;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      intcon <= intcon_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    unique case (state)
      RUN: begin
        if (q_count == 2'd3 && instr_boundary &&
            intcon[GIE_BIT] && pend) begin
          take    = 1'b1;
          state_n = ENTRY;
          cnt_n   = 2'd0;
        end
      end
      ENTRY: begin
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // Ordering sets priority: hardware flags beat software, take beats all.
  always_comb begin
    intcon_n = intcon;
    if (intcon_wr_en) intcon_n = intcon_wr_data;
    if (t0_ovf) intcon_n[T0IF_BIT] = 1'b1;
    if (int_edge) intcon_n[INTF_BIT] = 1'b1;
    if (rb_change) intcon_n[RBIF_BIT] = 1'b1;
    if (retfie_en) intcon_n[GIE_BIT] = 1'b1;
    if (take) intcon_n[GIE_BIT] = 1'b0;
  end

  assign intcon_q   = intcon;
  assign irq_take   = take;
  assign irq_flush  = take;
  assign irq_vector = INT_VECTOR;
  assign wake       = pend;

endmodule
